// File: rtl/ahb_tube_slave.sv
// rtl/ahb_tube_slave.sv - AHB tube slave: DATA writes feed a char FIFO drained via valid/ready.
// Optional TUBE_ERR_RESP_EN: two-cycle ERROR for non-word or offset 2/3 transfers.
module ahb_tube_slave #(
  parameter int DEPTH = 8
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSELS,
  input  logic [31:0] HADDRS,
  input  logic [1:0]  HTRANSS,
  input  logic        HWRITES,
  input  logic [2:0]  HSIZES,
  input  logic [2:0]  HBURSTS,
  input  logic [3:0]  HPROTS,
  input  logic [31:0] HWDATAS,
  input  logic        HREADYS,
  output logic        HREADYOUTS,
  output logic [1:0]  HRESPS,
  output logic [31:0] HRDATAS,
  output logic [7:0]  char_data,
  output logic        char_valid,
  input  logic        char_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

`ifdef TUBE_ERR_RESP_EN
  typedef enum logic [2:0] {S_IDLE, S_WDATA, S_RDATA, S_ERR1, S_ERR2} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_WDATA, S_RDATA} state_t;
`endif

  state_t      state, next_state, decoded;
  logic [1:0]  off_q;
  logic        accept, done, push, pop, full, empty;
  logic [AW:0] wptr, rptr, count;
  logic [7:0]  mem [DEPTH];
  logic [31:0] status;

`ifdef TUBE_ERR_RESP_EN
  logic unused;
  assign unused = ^{HBURSTS, HPROTS, HADDRS[31:4], HADDRS[1:0], HWDATAS[31:8]};
`else
  logic unused;
  assign unused = ^{HBURSTS, HPROTS, HSIZES, HADDRS[31:4], HADDRS[1:0], HWDATAS[31:8]};
`endif

  // FIFO with one extra pointer bit so full and empty are distinguishable
  assign count  = wptr - rptr;
  assign empty  = (wptr == rptr);
  assign full   = (wptr == {~rptr[AW], rptr[AW-1:0]});
  assign pop    = !empty && char_ready;
  assign char_valid = !empty;
  assign char_data  = mem[rptr[AW-1:0]];
  assign status = {16'h0, 8'(count), 6'h0, full, empty};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
    end
  end

  always_ff @(posedge HCLK) begin
    if (push) mem[wptr[AW-1:0]] <= HWDATAS[7:0];
  end

  assign accept = HSELS && HTRANSS[1] && HREADYS;

  always_comb begin
    decoded = HWRITES ? S_WDATA : S_RDATA;
`ifdef TUBE_ERR_RESP_EN
    if (HSIZES != 3'b010 || HADDRS[3]) decoded = S_ERR1;
`endif
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= S_IDLE;
      off_q <= 2'b00;
    end else begin
      state <= next_state;
      if (done && accept) off_q <= HADDRS[3:2];
    end
  end

  always_comb begin
    next_state = state;
`ifdef TUBE_ERR_RESP_EN
    if (state == S_ERR1) next_state = S_ERR2;
    else
`endif
    if (done) next_state = accept ? decoded : S_IDLE;
  end

  always_comb begin
    done    = 1'b1;
    HRESPS  = 2'b00;
    HRDATAS = 32'h0;
    push    = 1'b0;
    case (state)
      S_WDATA: begin
        done = !full;
        push = !full && (off_q == 2'd0);
      end
      S_RDATA: begin
        if (off_q == 2'd1) HRDATAS = status;
      end
`ifdef TUBE_ERR_RESP_EN
      S_ERR1: begin
        done   = 1'b0;
        HRESPS = 2'b01;
      end
      S_ERR2: HRESPS = 2'b01;
`endif
      default: done = 1'b1;
    endcase
    HREADYOUTS = done;
  end
endmodule

// File: tb/tb_ahb_tube_slave.sv
// tb/tb_ahb_tube_slave.sv - table-driven and randomized bench for ahb_tube_slave with a queue model.
`timescale 1ns/1ps
module tb_ahb_tube_slave;
  localparam int DEPTH = 8;

  logic        HCLK = 1'b0, HRESETn = 1'b0, HSELS = 1'b0, HWRITES = 1'b0;
  logic [31:0] HADDRS = 32'h0, HWDATAS = 32'h0;
  logic [1:0]  HTRANSS = 2'b00;
  logic [2:0]  HSIZES = 3'b010, HBURSTS = 3'b000;
  logic [3:0]  HPROTS = 4'h0;
  logic        HREADYS, HREADYOUTS, char_valid;
  logic        char_ready = 1'b0;
  logic [1:0]  HRESPS;
  logic [31:0] HRDATAS;
  logic [7:0]  char_data;

  assign HREADYS = HREADYOUTS;
  always #5 HCLK = ~HCLK;

  ahb_tube_slave #(.DEPTH(DEPTH)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSELS(HSELS), .HADDRS(HADDRS), .HTRANSS(HTRANSS),
    .HWRITES(HWRITES), .HSIZES(HSIZES), .HBURSTS(HBURSTS), .HPROTS(HPROTS),
    .HWDATAS(HWDATAS), .HREADYS(HREADYS), .HREADYOUTS(HREADYOUTS), .HRESPS(HRESPS),
    .HRDATAS(HRDATAS), .char_data(char_data), .char_valid(char_valid), .char_ready(char_ready)
  );

  int checks = 0, passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic        wr;
    logic [1:0]  off;
    logic [31:0] wdata;
    logic [2:0]  size;
    logic        rdy;
    logic        chk;
    logic [31:0] exp;
  } op_t;

  function automatic op_t mk(input logic wr, input logic [1:0] off, input logic [31:0] wdata,
                             input logic [2:0] size, input logic rdy, input logic chk,
                             input logic [31:0] exp);
    op_t o;
    o.sel = 1'b1; o.trans = 2'b10; o.wr = wr; o.off = off; o.wdata = wdata;
    o.size = size; o.rdy = rdy; o.chk = chk; o.exp = exp;
    return o;
  endfunction

  function automatic logic is_err(input op_t o);
`ifdef TUBE_ERR_RESP_EN
    return (o.size != 3'b010) || o.off[1];
`else
    return 1'b0;
`endif
  endfunction

  // Data-phase description published by the driver for the model
  logic        dp_act = 1'b0, dp_wr = 1'b0, dp_err = 1'b0, force_rdy = 1'b0;
  logic [1:0]  dp_off = 2'b00;
  logic [31:0] dp_wdata = 32'h0;
  int          dp_id = 0;

  // Reference model: the FIFO is a byte queue; pushes/pops applied per completed cycle
  logic [7:0] q[$];
  int last_id = -1, err_cyc = 0, sz;
  always @(negedge HCLK) begin
    if (!HRESETn) begin
      q.delete();
    end else begin
      sz = q.size();
      check("char_valid", char_valid, sz != 0);
      if (sz != 0) check("char_data", char_data, q[0]);
      if (dp_act) begin
        if (dp_id != last_id) begin err_cyc = 0; last_id = dp_id; end
        else err_cyc++;
        if (dp_err) begin
          check("err_resp", HRESPS, 2'b01);
          check("err_ready", HREADYOUTS, err_cyc != 0);
        end else begin
          check("resp", HRESPS, 2'b00);
          if (dp_wr) check("wr_ready", HREADYOUTS, sz < DEPTH);
          else begin
            check("rd_ready", HREADYOUTS, 1'b1);
            check("rdata", HRDATAS, (dp_off == 2'd1) ?
                  {16'h0, 8'(sz), 6'h0, sz == DEPTH, sz == 0} : 32'h0);
          end
        end
      end else begin
        check("idle_outs", {HREADYOUTS, HRESPS, HRDATAS}, {1'b1, 2'b00, 32'h0});
      end
      if (char_valid && char_ready && sz != 0) void'(q.pop_front());
      if (dp_act && dp_wr && !dp_err && dp_off == 2'd0 && sz < DEPTH) q.push_back(dp_wdata[7:0]);
    end
  end

  // Pipelined AHB master: next address phase overlaps current data phase
  task automatic run_ops(input op_t ops[$], input logic idle_rdy);
    op_t ap, dp, idle_op;
    logic ap_v, dp_v, ready_prev;
    int i, guard;
    idle_op = mk(1'b0, 2'd0, 32'h0, 3'b010, 1'b0, 1'b0, 32'h0);
    idle_op.sel = 1'b0; idle_op.trans = 2'b00;
    ap = idle_op; dp = idle_op; ap_v = 1'b0; dp_v = 1'b0; ready_prev = 1'b1; i = 0; guard = 0;
    while ((i < ops.size() || ap_v || dp_v) && HRESETn) begin
      @(posedge HCLK); #1;
      if (ready_prev) begin
        dp = ap; dp_v = ap_v;
        if (i < ops.size()) begin ap = ops[i]; i++; end
        else ap = idle_op;
        ap_v = ap.sel && ap.trans[1];
        HSELS = ap.sel; HTRANSS = ap.trans; HWRITES = ap.wr; HSIZES = ap.size;
        HADDRS = 32'h2000_0000 | {28'h0, ap.off, 2'b00};
        HBURSTS = 3'($urandom); HPROTS = 4'($urandom);
        if (dp_v) dp_id++;
        HWDATAS = dp_v ? dp.wdata : 32'h0;
        dp_act = dp_v; dp_wr = dp.wr; dp_off = dp.off; dp_wdata = dp.wdata;
        dp_err = dp_v && is_err(dp);
      end
      char_ready = force_rdy ? 1'b1 : (dp_v ? dp.rdy : idle_rdy);
      @(negedge HCLK);
      ready_prev = HREADYOUTS;
      if (dp_v && HREADYOUTS && dp.chk && HRESETn) check("tbl_rdata", HRDATAS, dp.exp);
      if (!HREADYOUTS) begin
        guard++;
        if (guard > 200) begin
          checks++;
          $display("FAIL stall_timeout: HREADYOUTS still 0 after %0d cycles, required 1", guard);
          break;
        end
      end else guard = 0;
    end
    @(posedge HCLK); #1;
    HSELS = 1'b0; HTRANSS = 2'b00; dp_act = 1'b0; dp_err = 1'b0;
  endtask

  task automatic drain();
    int n;
    force_rdy = 1'b1; char_ready = 1'b1; n = 0;
    while (char_valid && n < 64) begin @(negedge HCLK); n++; end
    check("drained", {char_valid, 8'(q.size())}, 9'h0);
    @(posedge HCLK); #1;
    force_rdy = 1'b0; char_ready = 1'b0;
  endtask

  op_t ops[$];
  op_t r;

  initial begin
    #2;
    check("rst_outs", {HREADYOUTS, HRESPS, HRDATAS, char_valid}, {1'b1, 2'b00, 32'h0, 1'b0});
    @(negedge HCLK); HRESETn = 1'b1;

    // Single word write with consumer ready
    ops = '{mk(1'b1, 2'd0, 32'h31, 3'b010, 1'b1, 1'b0, 32'h0)};
    run_ops(ops, 1'b1);
    ops = '{mk(1'b0, 2'd1, 32'h0, 3'b010, 1'b0, 1'b1, 32'h1)};
    run_ops(ops, 1'b0);

    // Nine back-to-back writes into an 8-deep FIFO with consumer stalled
    ops.delete();
    for (int k = 0; k < 9; k++) ops.push_back(mk(1'b1, 2'd0, 32'h41 + k, 3'b010, 1'b0, 1'b0, 32'h0));
    fork
      run_ops(ops, 1'b0);
      begin
        repeat (15) @(negedge HCLK);
        check("full_stall", {HREADYOUTS, 8'(q.size())}, {1'b0, 8'd8});
        force_rdy = 1'b1; char_ready = 1'b1;
      end
    join
    drain();

    // Status with three entries, then after draining
    ops = '{mk(1'b1, 2'd0, 32'h61, 3'b010, 1'b0, 1'b0, 32'h0),
            mk(1'b1, 2'd0, 32'h62, 3'b010, 1'b0, 1'b0, 32'h0),
            mk(1'b1, 2'd0, 32'h63, 3'b010, 1'b0, 1'b0, 32'h0),
            mk(1'b0, 2'd1, 32'h0,  3'b010, 1'b0, 1'b1, 32'h0000_0300)};
    run_ops(ops, 1'b0);
    drain();
    ops = '{mk(1'b0, 2'd1, 32'h0, 3'b010, 1'b0, 1'b1, 32'h0000_0001)};
    run_ops(ops, 1'b0);

    // Push and pop in the same cycle at count 4; ignored offsets
    ops = '{mk(1'b1, 2'd0, 32'h71, 3'b010, 1'b0, 1'b0, 32'h0),
            mk(1'b1, 2'd0, 32'h72, 3'b010, 1'b0, 1'b0, 32'h0),
            mk(1'b1, 2'd0, 32'h73, 3'b010, 1'b0, 1'b0, 32'h0),
            mk(1'b1, 2'd0, 32'h74, 3'b010, 1'b0, 1'b0, 32'h0),
            mk(1'b1, 2'd0, 32'h75, 3'b010, 1'b1, 1'b0, 32'h0),
            mk(1'b0, 2'd1, 32'h0,  3'b010, 1'b0, 1'b1, 32'h0000_0400),
            mk(1'b1, 2'd1, 32'hff, 3'b010, 1'b0, 1'b0, 32'h0),
            mk(1'b1, 2'd2, 32'hee, 3'b010, 1'b0, 1'b0, 32'h0),
            mk(1'b0, 2'd0, 32'h0,  3'b010, 1'b0, 1'b1, 32'h0),
            mk(1'b0, 2'd3, 32'h0,  3'b010, 1'b0, 1'b1, 32'h0),
            mk(1'b0, 2'd1, 32'h0,  3'b010, 1'b0, 1'b1, 32'h0000_0400)};
    run_ops(ops, 1'b0);
    drain();

    // Byte-size write: pushes by default, ERROR with the feature
    ops = '{mk(1'b1, 2'd0, 32'h7a, 3'b000, 1'b0, 1'b0, 32'h0),
`ifdef TUBE_ERR_RESP_EN
            mk(1'b0, 2'd1, 32'h0,  3'b010, 1'b0, 1'b1, 32'h0000_0001)};
`else
            mk(1'b0, 2'd1, 32'h0,  3'b010, 1'b0, 1'b1, 32'h0000_0100)};
`endif
    run_ops(ops, 1'b0);
    drain();

    // Asynchronous reset while a write is stalled on a full FIFO
    ops.delete();
    for (int k = 0; k < 9; k++) ops.push_back(mk(1'b1, 2'd0, 32'h80 + k, 3'b010, 1'b0, 1'b0, 32'h0));
    fork
      run_ops(ops, 1'b0);
      begin
        repeat (15) @(posedge HCLK);
        #3 HRESETn = 1'b0;
        #1 check("rst_async", {HREADYOUTS, HRESPS, HRDATAS, char_valid}, {1'b1, 2'b00, 32'h0, 1'b0});
      end
    join
    @(negedge HCLK); HRESETn = 1'b1;
    ops = '{mk(1'b0, 2'd1, 32'h0, 3'b010, 1'b0, 1'b1, 32'h0000_0001)};
    run_ops(ops, 1'b0);

    // Randomized traffic against the queue model
    ops.delete();
    for (int k = 0; k < 400; k++) begin
      r = mk(1'($urandom), 2'($urandom), $urandom, ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 2)) : 3'b010,
             ($urandom_range(0, 2) == 0), 1'b0, 32'h0);
      r.sel = ($urandom_range(0, 5) != 0);
      r.trans = 2'($urandom);
      ops.push_back(r);
    end
    run_ops(ops, 1'b0);
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
